// File: rtl/kf8237_channel_programmer.sv
// kf8237_channel_programmer
//   Programs one 8237 DMA channel: masks it, clears the byte-pointer flip-flop,
//   writes the 16-bit base/current address and word count as low/high byte
//   pairs, then unmasks it. Every bus access is SETUP -> STROBE -> HOLD.
//
//   Optional feature macro: KF8237_PROGRAMMER_VERIFY_EN
//     When defined, the four programmed bytes are read back (after a second
//     flip-flop clear) and compared. A mismatch skips the unmask and reports
//     error together with done. When undefined, io_read_n is tied 1 and
//     error is tied 0.
//
//   Parameter: STROBE_CYCLES (1..15) clocks the strobe is held low.
//   Ports:
//     clock, reset          rising-edge clock, synchronous active-high reset
//     start                 request pulse, sampled only while idle
//     channel/address/count target channel and 16-bit values, latched on start
//     busy, done, error     status; done is a one-cycle pulse, error valid with done
//     io_address            8237 register select A3..A0
//     io_write_n/io_read_n  active-low strobes
//     chip_select_n         active-low, low for the whole of each access
//     data_bus_out          write data
//     data_bus_in           read data from the 8237
module kf8237_channel_programmer #(
  parameter int STROBE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  channel,
  input  logic [15:0] address,
  input  logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  io_address,
  output logic        io_write_n,
  output logic        io_read_n,
  output logic        chip_select_n,
  output logic [7:0]  data_bus_out,
  input  logic [7:0]  data_bus_in
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD, PH_DONE
  } phase_e;

  // Ordered so that plain increment walks the sequence; the verify steps
  // sit between CNT_HI and UNMASK and are skipped explicitly when unused.
  typedef enum logic [3:0] {
    ACC_MASK, ACC_CLR, ACC_ADDR_LO, ACC_ADDR_HI, ACC_CNT_LO, ACC_CNT_HI,
    ACC_CLR_V, ACC_RD_ADDR_LO, ACC_RD_ADDR_HI, ACC_RD_CNT_LO, ACC_RD_CNT_HI,
    ACC_UNMASK
  } access_e;

  // Register select for an access.
  function automatic logic [3:0] access_reg(input access_e acc, input logic [1:0] ch);
    case (acc)
      ACC_MASK, ACC_UNMASK:                                    access_reg = 4'hA;
      ACC_CLR, ACC_CLR_V:                                      access_reg = 4'hC;
      ACC_ADDR_LO, ACC_ADDR_HI, ACC_RD_ADDR_LO, ACC_RD_ADDR_HI: access_reg = {1'b0, ch, 1'b0};
      ACC_CNT_LO, ACC_CNT_HI, ACC_RD_CNT_LO, ACC_RD_CNT_HI:     access_reg = {1'b0, ch, 1'b1};
      default:                                                 access_reg = 4'h0;
    endcase
  endfunction

  // Byte written by an access, or the byte a read access expects back.
  function automatic logic [7:0] access_byte(input access_e acc, input logic [1:0] ch,
                                             input logic [15:0] addr, input logic [15:0] cnt);
    case (acc)
      ACC_MASK:                     access_byte = {5'b00000, 1'b1, ch};
      ACC_UNMASK:                   access_byte = {6'b000000, ch};
      ACC_ADDR_LO, ACC_RD_ADDR_LO:  access_byte = addr[7:0];
      ACC_ADDR_HI, ACC_RD_ADDR_HI:  access_byte = addr[15:8];
      ACC_CNT_LO, ACC_RD_CNT_LO:    access_byte = cnt[7:0];
      ACC_CNT_HI, ACC_RD_CNT_HI:    access_byte = cnt[15:8];
      default:                      access_byte = 8'h00;
    endcase
  endfunction

  function automatic logic access_is_read(input access_e acc);
    access_is_read = (acc == ACC_RD_ADDR_LO) || (acc == ACC_RD_ADDR_HI) ||
                     (acc == ACC_RD_CNT_LO)  || (acc == ACC_RD_CNT_HI);
  endfunction

  phase_e      phase_r, phase_next_s;
  access_e     access_r, access_next_s;
  logic [3:0]  strobe_cnt_r, strobe_cnt_next_s;
  logic [1:0]  ch_r, sel_ch_s;
  logic [15:0] addr_r, cnt_r, sel_addr_s, sel_cnt_s;
  logic        in_access_s, next_is_read_s;
  logic [3:0]  io_address_next_s;
  logic [7:0]  data_next_s;
  logic        write_n_next_s;

`ifdef KF8237_PROGRAMMER_VERIFY_EN
  logic        mismatch_r, mismatch_next_s;
  logic        read_n_next_s;
`endif

  // Next-state logic: phase/access sequencing and strobe timing.
  always_comb begin
    phase_next_s      = phase_r;
    access_next_s     = access_r;
    strobe_cnt_next_s = strobe_cnt_r;
`ifdef KF8237_PROGRAMMER_VERIFY_EN
    mismatch_next_s   = mismatch_r;
`endif
    case (phase_r)
      PH_IDLE: begin
        if (start) begin
          phase_next_s  = PH_SETUP;
          access_next_s = ACC_MASK;
`ifdef KF8237_PROGRAMMER_VERIFY_EN
          mismatch_next_s = 1'b0;
`endif
        end else begin
          phase_next_s = PH_IDLE;
        end
      end
      PH_SETUP: begin
        phase_next_s      = PH_STROBE;
        strobe_cnt_next_s = 4'd0;
      end
      PH_STROBE: begin
        if (strobe_cnt_r == STROBE_LAST) begin
          phase_next_s = PH_HOLD;
`ifdef KF8237_PROGRAMMER_VERIFY_EN
          // Read data is taken on the edge that ends the strobe.
          if (access_is_read(access_r) &&
              (data_bus_in != access_byte(access_r, ch_r, addr_r, cnt_r))) begin
            mismatch_next_s = 1'b1;
          end else begin
            mismatch_next_s = mismatch_r;
          end
`endif
        end else begin
          strobe_cnt_next_s = strobe_cnt_r + 4'd1;
        end
      end
      PH_HOLD: begin
        phase_next_s = PH_SETUP;
        case (access_r)
`ifdef KF8237_PROGRAMMER_VERIFY_EN
          ACC_CNT_HI: access_next_s = ACC_CLR_V;
          ACC_RD_CNT_HI: begin
            if (mismatch_r) begin
              phase_next_s = PH_DONE;
            end else begin
              access_next_s = ACC_UNMASK;
            end
          end
`else
          ACC_CNT_HI: access_next_s = ACC_UNMASK;
`endif
          ACC_UNMASK: phase_next_s  = PH_DONE;
          default:    access_next_s = access_e'(access_r + 4'd1);
        endcase
      end
      PH_DONE: phase_next_s = PH_IDLE;
      default: phase_next_s = PH_IDLE;
    endcase
  end

  // Output decode from the next state so the outputs can be registered
  // without adding a cycle; on the start cycle the live inputs are used.
  always_comb begin
    if (phase_r == PH_IDLE) begin
      sel_ch_s   = channel;
      sel_addr_s = address;
      sel_cnt_s  = count;
    end else begin
      sel_ch_s   = ch_r;
      sel_addr_s = addr_r;
      sel_cnt_s  = cnt_r;
    end
    in_access_s    = (phase_next_s == PH_SETUP) || (phase_next_s == PH_STROBE) ||
                     (phase_next_s == PH_HOLD);
    next_is_read_s = access_is_read(access_next_s);
    if (in_access_s) begin
      io_address_next_s = access_reg(access_next_s, sel_ch_s);
      data_next_s       = next_is_read_s ? 8'h00
                                         : access_byte(access_next_s, sel_ch_s, sel_addr_s, sel_cnt_s);
    end else begin
      io_address_next_s = 4'h0;
      data_next_s       = 8'h00;
    end
    write_n_next_s = !((phase_next_s == PH_STROBE) && !next_is_read_s);
`ifdef KF8237_PROGRAMMER_VERIFY_EN
    read_n_next_s  = !((phase_next_s == PH_STROBE) && next_is_read_s);
`endif
  end

  // State registers and request latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_r      <= PH_IDLE;
      access_r     <= ACC_MASK;
      strobe_cnt_r <= 4'd0;
      ch_r         <= 2'd0;
      addr_r       <= 16'h0000;
      cnt_r        <= 16'h0000;
    end else begin
      phase_r      <= phase_next_s;
      access_r     <= access_next_s;
      strobe_cnt_r <= strobe_cnt_next_s;
      if ((phase_r == PH_IDLE) && start) begin
        ch_r   <= channel;
        addr_r <= address;
        cnt_r  <= count;
      end
    end
  end

  // Registered bus and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      chip_select_n <= 1'b1;
      io_write_n    <= 1'b1;
      io_address    <= 4'h0;
      data_bus_out  <= 8'h00;
    end else begin
      busy          <= in_access_s;
      done          <= (phase_next_s == PH_DONE);
      chip_select_n <= !in_access_s;
      io_write_n    <= write_n_next_s;
      io_address    <= io_address_next_s;
      data_bus_out  <= data_next_s;
    end
  end

`ifdef KF8237_PROGRAMMER_VERIFY_EN
  // Readback state and verify-only outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      mismatch_r <= 1'b0;
      io_read_n  <= 1'b1;
      error      <= 1'b0;
    end else begin
      mismatch_r <= mismatch_next_s;
      io_read_n  <= read_n_next_s;
      error      <= (phase_next_s == PH_DONE) && mismatch_next_s;
    end
  end
`else
  logic unused_data_s;
  assign unused_data_s = ^data_bus_in;
  assign io_read_n     = 1'b1;
  assign error         = 1'b0;
`endif

endmodule

// File: doc/kf8237_channel_programmer.md
KF8237_CHANNEL_PROGRAMMER -- requirements
Module: KF8237_Channel_Programmer

Interface
REQ-001 Parameter STROBE_CYCLES, default 1: clocks the strobe is held low per access; legal range 1..15.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only while idle.
REQ-005 channel  input  2  target DMA channel.
REQ-006 address  input  16  base/current address to program.
REQ-007 count  input  16  base/current word count to program.
REQ-008 busy  output  1  sequence in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 error  output  1  readback mismatch flag, valid with done.
REQ-011 io_address  output  4  8237 register select A3..A0.
REQ-012 io_write_n  output  1  active-low write strobe.
REQ-013 io_read_n  output  1  active-low read strobe.
REQ-014 chip_select_n  output  1  active-low chip select; low for the whole duration of each access.
REQ-015 data_bus_out  output  8  write data.
REQ-016 data_bus_in  input  8  read data from 8237.

Function
REQ-017 When idle and start=1, the block SHALL latch channel/address/count, assert busy next cycle, and ignore start until idle again.
REQ-018 Each access SHALL be SETUP (1 clk, strobes high, io_address/data valid) -> STROBE (STROBE_CYCLES clks, strobe low) -> HOLD (1 clk, strobe high, io_address/data still valid).
REQ-019 Write sequence, in order: MASK (io_address 0xA, data {5'b0,1,ch}), CLR_FF (0xC, data 0x00), ADDR_LO (2*ch, address[7:0]), ADDR_HI (2*ch, address[15:8]), CNT_LO (2*ch+1, count[7:0]), CNT_HI (2*ch+1, count[15:8]).
REQ-020 After the write sequence, UNMASK (0xA, data {6'b0,ch}) SHALL be issued, then done=1 for one cycle with busy=0 in the same cycle.
REQ-021 Outside accesses: chip_select_n, io_write_n and io_read_n SHALL be 1; io_address and data_bus_out SHALL be 0.
REQ-022 io_write_n and io_read_n SHALL never be low simultaneously.
REQ-023 Total latency with STROBE_CYCLES=1 and no verify: 7 accesses x 3 = 21 busy cycles; done in cycle 22 after start is sampled.
REQ-024 error SHALL be 0 whenever done=0.

Reset
REQ-025 On reset: FSM idle; busy=0, done=0, error=0; all strobes and chip_select_n = 1; io_address=0, data_bus_out=0.
REQ-026 Reset mid-sequence SHALL abort at the next edge with no done pulse; the channel MAY remain masked.

Configuration
REQ-027 Macro KF8237_PROGRAMMER_VERIFY_EN, when defined, SHALL insert between CNT_HI and UNMASK: CLR_FF, then four reads (2*ch, 2*ch, 2*ch+1, 2*ch+1) using io_read_n, sampling data_bus_in on the last STROBE-cycle edge.
REQ-028 With verify: read bytes SHALL be compared against address lo/hi and count lo/hi; on any mismatch, UNMASK SHALL be skipped and done=1 with error=1; on a full match, UNMASK SHALL be issued and error=0.
REQ-029 With verify, latency (STROBE_CYCLES=1, match) SHALL be 12 accesses = 36 busy cycles; done in cycle 37.
REQ-030 Without the macro, no read access SHALL occur, io_read_n SHALL be tied 1, and error SHALL be tied 0.

Verification
REQ-031 ch=2, address=0x1234, count=0x00FF, no verify -> writes (0xA,0x06), (0xC,0x00), (0x4,0x34), (0x4,0x12), (0x5,0xFF), (0x5,0x00), (0xA,0x02); done in cycle 22.
REQ-032 Verify enabled, model returns 0x34,0x12,0xFF,0x00 -> error=0, UNMASK (0xA,0x02) issued, done in cycle 37.
REQ-033 Verify enabled, model returns 0x35 for the first read -> done=1, error=1, no access to 0xA after CNT_HI.
REQ-034 Second start pulse during busy -> ignored; exactly one sequence and one done pulse.
REQ-035 Reset asserted during ADDR_HI STROBE -> next cycle all strobes=1, busy=0; no done pulse; a new start then runs the full sequence.
REQ-036 STROBE_CYCLES=3, ch=0 -> each strobe low exactly 3 cycles; done in cycle 36 without verify.
